// File: rtl/alu_issue_ctrl_if.sv
// Issue/writeback bus between the instruction source, the ALU and the controller.
// Debug read port included so the register file can be observed.
interface alu_issue_ctrl_if;
  logic        in_valid;
  logic [31:0] in_instr;
  logic        in_ready;
  logic [5:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic        alu_we;
  logic [31:0] alu_result;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        illegal;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  modport master (
    output in_valid, in_instr, alu_result, dbg_addr,
    input  in_ready, alu_op, alu_a, alu_b, alu_we,
    input  wb_valid, wb_addr, wb_data, illegal, dbg_data
  );

  modport slave (
    input  in_valid, in_instr, alu_result, dbg_addr,
    output in_ready, alu_op, alu_a, alu_b, alu_we,
    output wb_valid, wb_addr, wb_data, illegal, dbg_data
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Multi-cycle ALU issue/writeback controller with a 32x32 register file.
// One instruction in flight; accept, toggle ALU enable, write back, idle.
module alu_issue_ctrl (
  input logic           clk,
  input logic           rst_n,
  alu_issue_ctrl_if.slave bus
);
  localparam int NREGS = 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_WAIT,
    S_WB
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_rf [NREGS];
  logic [5:0]  r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic        r_we;
  logic [4:0]  r_dest;
  logic        r_wb_valid;
  logic [4:0]  r_wb_addr;
  logic [31:0] r_wb_data;
  logic        r_illegal;

  logic [5:0]  w_opc;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [4:0]  w_shamt;
  logic [5:0]  w_funct;
  logic [15:0] w_imm;
  logic [31:0] w_rs_val;
  logic [31:0] w_rt_val;
  logic        w_shift;
  logic        w_var;
  logic        w_rr;
  logic        w_simm;
  logic        w_zimm;
  logic        w_legal;
  logic [5:0]  w_dec_op;
  logic [31:0] w_dec_a;
  logic [31:0] w_dec_b;
  logic [4:0]  w_dec_dest;
  logic        w_accept;

  assign w_opc   = bus.in_instr[31:26];
  assign w_rs    = bus.in_instr[25:21];
  assign w_rt    = bus.in_instr[20:16];
  assign w_rd    = bus.in_instr[15:11];
  assign w_shamt = bus.in_instr[10:6];
  assign w_funct = bus.in_instr[5:0];
  assign w_imm   = bus.in_instr[15:0];

  assign w_rs_val = (w_rs == 5'd0) ? 32'd0 : r_rf[w_rs];
  assign w_rt_val = (w_rt == 5'd0) ? 32'd0 : r_rf[w_rt];

  assign w_shift = (w_opc == 6'd0) &&
                   (w_funct inside {6'h00, 6'h02, 6'h03});
  assign w_var   = (w_opc == 6'd0) && (w_funct == 6'h04);
  assign w_rr    = (w_opc == 6'd0) &&
                   (w_funct inside {6'h20, 6'h21, 6'h22, 6'h23,
                                    6'h24, 6'h25, 6'h26, 6'h27,
                                    6'h2a, 6'h2b});
  assign w_simm  = w_opc inside {6'd8, 6'd9, 6'd10};
  assign w_zimm  = w_opc inside {6'd13, 6'd14, 6'd15};

  always_comb begin
    w_legal    = 1'b1;
    w_dec_op   = w_opc;
    w_dec_a    = w_rs_val;
    w_dec_b    = w_rt_val;
    w_dec_dest = w_rt;
    unique case (1'b1)
      w_shift: begin
        w_dec_op   = w_funct;
        w_dec_a    = w_rt_val;
        w_dec_b    = {27'd0, w_shamt};
        w_dec_dest = w_rd;
      end
      w_var: begin
        w_dec_op   = w_funct;
        w_dec_a    = w_rt_val;
        w_dec_b    = w_rs_val;
        w_dec_dest = w_rd;
      end
      w_rr: begin
        w_dec_op   = w_funct;
        w_dec_dest = w_rd;
      end
      w_simm: w_dec_b = {{16{w_imm[15]}}, w_imm};
      w_zimm: w_dec_b = {16'd0, w_imm};
      default: w_legal = 1'b0;
    endcase
  end

  assign w_accept = bus.in_valid && (r_state == S_IDLE);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_accept) w_next = w_legal ? S_EXEC : S_WB;
      S_EXEC: w_next = S_WAIT;
      S_WAIT: w_next = S_WB;
      S_WB:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) r_rf[i] <= '0;
      r_op       <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_we       <= 1'b0;
      r_dest     <= '0;
      r_wb_valid <= 1'b0;
      r_wb_addr  <= '0;
      r_wb_data  <= '0;
      r_illegal  <= 1'b0;
    end else begin
      r_wb_valid <= 1'b0;
      r_illegal  <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_accept && w_legal) begin
            r_op   <= w_dec_op;
            r_a    <= w_dec_a;
            r_b    <= w_dec_b;
            r_dest <= w_dec_dest;
          end else if (w_accept) begin
            r_illegal <= 1'b1;
          end
        end
        S_EXEC: r_we <= ~r_we;
        S_WAIT: begin
          r_wb_valid <= 1'b1;
          r_wb_addr  <= r_dest;
          r_wb_data  <= bus.alu_result;
          // Register 0 is hardwired; the pulse still reports the attempt
          if (r_dest != 5'd0) r_rf[r_dest] <= bus.alu_result;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready = (r_state == S_IDLE);
  assign bus.alu_op   = r_op;
  assign bus.alu_a    = r_a;
  assign bus.alu_b    = r_b;
  assign bus.alu_we   = r_we;
  assign bus.wb_valid = r_wb_valid;
  assign bus.wb_addr  = r_wb_addr;
  assign bus.wb_data  = r_wb_data;
  assign bus.illegal  = r_illegal;
  assign bus.dbg_data = (bus.dbg_addr == 5'd0) ? 32'd0 : r_rf[bus.dbg_addr];
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU attached.
// Each task drives one scenario and checks against hand-computed values.
module tb_alu_issue_ctrl;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   we_toggles;

  alu_issue_ctrl_if bus ();

  alu_issue_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(bus.alu_we) we_toggles++;

  // Reference ALU
  always_comb begin
    bus.alu_result = 32'd0;
    case (bus.alu_op)
      6'h00: bus.alu_result = bus.alu_a << bus.alu_b[4:0];
      6'h02: bus.alu_result = bus.alu_a >> bus.alu_b[4:0];
      6'h03: bus.alu_result = $signed(bus.alu_a) >>> bus.alu_b[4:0];
      6'h04: bus.alu_result = bus.alu_a << bus.alu_b[4:0];
      6'h20, 6'h21, 6'd8, 6'd9:
             bus.alu_result = bus.alu_a + bus.alu_b;
      6'h22, 6'h23: bus.alu_result = bus.alu_a - bus.alu_b;
      6'h24: bus.alu_result = bus.alu_a & bus.alu_b;
      6'h25, 6'd13: bus.alu_result = bus.alu_a | bus.alu_b;
      6'h26, 6'd14: bus.alu_result = bus.alu_a ^ bus.alu_b;
      6'h27: bus.alu_result = ~(bus.alu_a | bus.alu_b);
      6'h2a, 6'd10:
        bus.alu_result = {31'd0, $signed(bus.alu_a) < $signed(bus.alu_b)};
      6'h2b: bus.alu_result = {31'd0, bus.alu_a < bus.alu_b};
      6'd15: bus.alu_result = bus.alu_b << 16;
      default: bus.alu_result = 32'd0;
    endcase
  end

  task automatic send(input logic [31:0] ins);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_instr = ins;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_instr = 32'hDEAD_BEEF;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_ready got=%b exp=1", bus.in_ready);
    end
    total++;
    if (bus.alu_op !== 6'd0 || bus.alu_a !== 32'd0 || bus.alu_b !== 32'd0) begin
      bad++;
      $display("FAIL reset_alu got=%h/%h/%h exp=0/0/0",
               bus.alu_op, bus.alu_a, bus.alu_b);
    end
    total++;
    if (bus.alu_we !== 1'b0 || bus.wb_valid !== 1'b0 || bus.illegal !== 1'b0) begin
      bad++;
      $display("FAIL reset_pulses got=%b%b%b exp=000",
               bus.alu_we, bus.wb_valid, bus.illegal);
    end
    bus.dbg_addr = 5'd1;
    #1;
    total++;
    if (bus.dbg_data !== 32'd0) begin
      bad++; $display("FAIL reset_r1 got=%h exp=0", bus.dbg_data);
    end
  endtask

  task automatic test_addi();
    we_toggles = 0;
    send(32'h2001_0005);
    total++;
    if (bus.alu_op !== 6'd8 || bus.alu_a !== 32'd0 || bus.alu_b !== 32'd5) begin
      bad++;
      $display("FAIL addi_operands got=%h/%h/%h exp=08/0/5",
               bus.alu_op, bus.alu_a, bus.alu_b);
    end
    total++;
    if (bus.in_ready !== 1'b0 || bus.alu_we !== 1'b0) begin
      bad++;
      $display("FAIL addi_e0 ready/we got=%b/%b exp=0/0",
               bus.in_ready, bus.alu_we);
    end
    step();
    total++;
    if (bus.alu_we !== 1'b1 || bus.wb_valid !== 1'b0) begin
      bad++;
      $display("FAIL addi_e1 we/wbv got=%b/%b exp=1/0",
               bus.alu_we, bus.wb_valid);
    end
    step();
    bus.dbg_addr = 5'd1;
    #1;
    total++;
    if (bus.wb_valid !== 1'b1 || bus.wb_addr !== 5'd1 || bus.wb_data !== 32'd5) begin
      bad++;
      $display("FAIL addi_wb got=%b/%0d/%h exp=1/1/5",
               bus.wb_valid, bus.wb_addr, bus.wb_data);
    end
    total++;
    if (bus.dbg_data !== 32'd5 || bus.in_ready !== 1'b0) begin
      bad++;
      $display("FAIL addi_r1 got=%h ready=%b exp=5 ready=0",
               bus.dbg_data, bus.in_ready);
    end
    step();
    total++;
    if (bus.wb_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL addi_e3 wbv/ready got=%b/%b exp=0/1",
               bus.wb_valid, bus.in_ready);
    end
    total++;
    if (we_toggles != 1) begin
      bad++; $display("FAIL addi_toggles got=%0d exp=1", we_toggles);
    end
  endtask

  task automatic test_imm_ext();
    send(32'h2002_FFFF);
    total++;
    if (bus.alu_b !== 32'hFFFF_FFFF) begin
      bad++; $display("FAIL sext_b got=%h exp=ffffffff", bus.alu_b);
    end
    step(); step(); step();
    send(32'h3403_FFFF);
    total++;
    if (bus.alu_op !== 6'd13 || bus.alu_b !== 32'h0000_FFFF) begin
      bad++;
      $display("FAIL zext_b got=%h/%h exp=0d/0000ffff", bus.alu_op, bus.alu_b);
    end
    step(); step(); step();
    bus.dbg_addr = 5'd2;
    #1;
    total++;
    if (bus.dbg_data !== 32'hFFFF_FFFF) begin
      bad++; $display("FAIL r2 got=%h exp=ffffffff", bus.dbg_data);
    end
    bus.dbg_addr = 5'd3;
    #1;
    total++;
    if (bus.dbg_data !== 32'h0000_FFFF) begin
      bad++; $display("FAIL r3 got=%h exp=0000ffff", bus.dbg_data);
    end
  endtask

  task automatic test_back_to_back();
    we_toggles = 0;
    send(32'h0001_20C0);
    total++;
    if (bus.alu_op !== 6'd0 || bus.alu_a !== 32'd5 || bus.alu_b !== 32'd3) begin
      bad++;
      $display("FAIL sll_operands got=%h/%h/%h exp=00/5/3",
               bus.alu_op, bus.alu_a, bus.alu_b);
    end
    step(); step(); step();
    send(32'h0024_2820);
    total++;
    if (bus.alu_op !== 6'h20 || bus.alu_a !== 32'd5 || bus.alu_b !== 32'd40) begin
      bad++;
      $display("FAIL add_operands got=%h/%h/%h exp=20/5/28",
               bus.alu_op, bus.alu_a, bus.alu_b);
    end
    step(); step();
    total++;
    if (bus.wb_addr !== 5'd5 || bus.wb_data !== 32'd45) begin
      bad++;
      $display("FAIL add_wb got=%0d/%0d exp=5/45", bus.wb_addr, bus.wb_data);
    end
    step();
    bus.dbg_addr = 5'd4;
    #1;
    total++;
    if (bus.dbg_data !== 32'd40) begin
      bad++; $display("FAIL r4 got=%0d exp=40", bus.dbg_data);
    end
    total++;
    if (we_toggles != 2) begin
      bad++; $display("FAIL b2b_toggles got=%0d exp=2", we_toggles);
    end
  endtask

  task automatic test_zero_dest();
    send(32'h0021_0020);
    step(); step();
    bus.dbg_addr = 5'd0;
    #1;
    total++;
    if (bus.wb_valid !== 1'b1 || bus.wb_addr !== 5'd0 || bus.wb_data !== 32'd10) begin
      bad++;
      $display("FAIL r0_wb got=%b/%0d/%0d exp=1/0/10",
               bus.wb_valid, bus.wb_addr, bus.wb_data);
    end
    total++;
    if (bus.dbg_data !== 32'd0) begin
      bad++; $display("FAIL r0_value got=%h exp=0", bus.dbg_data);
    end
    step();
  endtask

  task automatic test_illegal();
    logic [5:0]  op0;
    logic [31:0] b0;
    op0 = bus.alu_op;
    b0  = bus.alu_b;
    we_toggles = 0;
    send(32'hFC00_0000);
    total++;
    if (bus.illegal !== 1'b1 || bus.wb_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
      bad++;
      $display("FAIL ill_e0 got=%b/%b/%b exp=1/0/0",
               bus.illegal, bus.wb_valid, bus.in_ready);
    end
    step();
    total++;
    if (bus.illegal !== 1'b0 || bus.in_ready !== 1'b1 || bus.wb_valid !== 1'b0) begin
      bad++;
      $display("FAIL ill_e1 got=%b/%b/%b exp=0/1/0",
               bus.illegal, bus.in_ready, bus.wb_valid);
    end
    total++;
    if (we_toggles != 0 || bus.alu_op !== op0 || bus.alu_b !== b0) begin
      bad++;
      $display("FAIL ill_hold tog=%0d op=%h b=%h exp=0/%h/%h",
               we_toggles, bus.alu_op, bus.alu_b, op0, b0);
    end
  endtask

  task automatic test_reset_midflight();
    send(32'h2006_0007);
    step();
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.alu_op !== 6'd0 || bus.alu_b !== 32'd0 || bus.alu_we !== 1'b0 ||
        bus.wb_valid !== 1'b0 || bus.illegal !== 1'b0) begin
      bad++;
      $display("FAIL rst_outputs got=%h/%h/%b/%b/%b exp=0/0/0/0/0",
               bus.alu_op, bus.alu_b, bus.alu_we, bus.wb_valid, bus.illegal);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step(); step();
    bus.dbg_addr = 5'd6;
    #1;
    total++;
    if (bus.dbg_data !== 32'd0 || bus.wb_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_r6 got=%h wbv=%b exp=0 wbv=0",
               bus.dbg_data, bus.wb_valid);
    end
    bus.dbg_addr = 5'd5;
    #1;
    total++;
    if (bus.dbg_data !== 32'd0 || bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_r5 got=%h ready=%b exp=0 ready=1",
               bus.dbg_data, bus.in_ready);
    end
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    we_toggles   = 0;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_instr = 32'd0;
    bus.dbg_addr = 5'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    test_reset();
    test_addi();
    test_imm_ext();
    test_back_to_back();
    test_zero_dest();
    test_illegal();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Multi-cycle issue/writeback controller sitting directly upstream (and downstream) of the processor ALU. Accepts one decoded-format MIPS instruction word per handshake, reads operands from its internal 32x32 register file, drives the ALU operand/opcode inputs, fires the ALU's edge-sensitive enable (`alu_we` toggle), and writes the ALU result back to the register file. Processes one instruction at a time; 4-cycle issue-to-ready turnaround.

## Interface
- `NREGS`, 32: register count (fixed; 5-bit specifiers).
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  instruction word valid.
- `in_instr`  in  32  instruction: opcode[31:26], rs[25:21], rt[20:16], rd[15:11], shamt[10:6], funct[5:0], imm[15:0].
- `in_ready`  out  1  high only in IDLE (combinational from state).
- `alu_op`  out  6  ALU opcode (registered).
- `alu_a`  out  32  ALU operand 1 (registered).
- `alu_b`  out  32  ALU operand 2 (registered).
- `alu_we`  out  1  ALU trigger; toggles once per legal instruction.
- `alu_result`  in  32  ALU output.
- `wb_valid`  out  1  one-cycle pulse: register written.
- `wb_addr`  out  5  destination register of the pulse.
- `wb_data`  out  32  value written.
- `illegal`  out  1  one-cycle pulse: instruction undecodable, discarded.
- `dbg_addr`  in  5  debug read address.
- `dbg_data`  out  32  combinational read of `dbg_addr`; 0 for address 0.

## Operation
- Decode on accept (`in_valid && in_ready` at rising edge):
  - opcode 0 (R-type), funct in {0x00,0x02,0x03}: `alu_op`=funct, `alu_a`=R[rt], `alu_b`={27'b0,shamt}, dest rd.
  - opcode 0, funct 0x04: `alu_a`=R[rt], `alu_b`=R[rs], dest rd.
  - opcode 0, funct in {0x20,0x21,0x22,0x23,0x24,0x25,0x26,0x27,0x2a,0x2b}: `alu_a`=R[rs], `alu_b`=R[rt], dest rd.
  - opcode in {8,9,10}: `alu_op`=opcode, `alu_a`=R[rs], `alu_b`=sign-extended imm, dest rt.
  - opcode in {13,14,15}: `alu_op`=opcode, `alu_a`=R[rs], `alu_b`=zero-extended imm, dest rt.
  - anything else: illegal.
- R[0] reads 0 always; writes to register 0 are dropped (`wb_valid` still pulses with `wb_addr`=0, `wb_data`=result).
- FSM states IDLE, EXEC, WAIT, WB:
  - IDLE: legal accept -> EXEC (operands/op registered); illegal accept -> WB with `illegal`=1, no `alu_we` toggle, no write.
  - EXEC -> WAIT: `alu_we` inverts.
  - WAIT -> WB: sample `alu_result`, write R[dest], `wb_valid`=1, `wb_addr`/`wb_data` loaded.
  - WB -> IDLE: `wb_valid`/`illegal` return to 0.
- `in_instr` ignored outside IDLE; no hazard logic needed (write completes before next accept).

## Timing
- Reset (async, any state): state IDLE, all registers R0..R31=0, `alu_op`/`alu_a`/`alu_b`/`wb_addr`/`wb_data`=0, `alu_we`=0, `wb_valid`=0, `illegal`=0. In-flight instruction discarded, no write.
- Accept at edge E0; `alu_we` toggles at E1; result sampled and written at E2 (`alu_result` must be stable one full cycle after toggle); `wb_valid` high E2..E3; `in_ready` high from E3; next accept earliest at E4.
- Illegal: accept E0, `illegal` high E0..E1, `in_ready` high from E1.
- `dbg_data` reflects a write from the cycle after the writing edge.
- `alu_op`/`alu_a`/`alu_b` hold last values until next legal accept.

## Test plan
- Reset, then addi $1,$0,5 (0x20010005): `alu_op`=8, `alu_a`=0, `alu_b`=5; `alu_we` 0->1 at E1; with ALU attached R1=5, `wb_valid` pulse `wb_addr`=1 at E2; `in_ready` at E3.
- addi $2,$0,-1 (imm 0xFFFF) -> `alu_b`=0xFFFFFFFF; ori $3,$0,0xFFFF -> `alu_b`=0x0000FFFF, R3=0x0000FFFF.
- R1=5: sll $4,$1,3 -> `alu_a`=5, `alu_b`=3, R4=40; add $5,$1,$4 -> R5=45; `alu_we` toggled once per instruction.
- add $0,$1,$1 -> `wb_valid` pulse, `wb_addr`=0, `dbg_data` at addr 0 stays 0.
- opcode 0x3F -> `illegal` one-cycle pulse, no `alu_we` toggle, no `wb_valid`, `in_ready` next cycle.
- Deassert `rst_n` during WAIT -> all outputs 0 immediately, destination register unchanged (0), `in_ready`=1 after release.
